// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: opcode field geometry, the named opcodes,
// the legality check and the dispatch buffer state encoding.
package decode_pkg;

  localparam int OP_W      = 6;
  localparam int NUM_UNITS = 18;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 10;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 6'd5;
  localparam logic [OP_W-1:0] OP_SHR  = 6'd6;
  localparam logic [OP_W-1:0] OP_MUL  = 6'd7;
  localparam logic [OP_W-1:0] OP_DIV  = 6'd8;
  localparam logic [OP_W-1:0] OP_LD   = 6'd9;
  localparam logic [OP_W-1:0] OP_ST   = 6'd10;
  localparam logic [OP_W-1:0] OP_BR   = 6'd11;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd12;
  localparam logic [OP_W-1:0] OP_CALL = 6'd13;
  localparam logic [OP_W-1:0] OP_RET  = 6'd14;
  localparam logic [OP_W-1:0] OP_CMP  = 6'd15;
  localparam logic [OP_W-1:0] OP_MOV  = 6'd16;
  localparam logic [OP_W-1:0] OP_SYS  = 6'd17;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } disp_state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op < OP_W'(NUM_UNITS));
  endfunction

endpackage

// File: rtl/dispatch_skid.sv
// Two-entry word+opcode buffer (output register plus skid entry) with a
// registered ready, giving full throughput without a ready->ready path.
module dispatch_skid #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [OP_W-1:0]   push_op,
  input  logic              fire,
  output logic              in_ready,
  output logic              buf_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [OP_W-1:0]   out_op
);
  import decode_pkg::*;

  disp_state_e       state_r, state_next_s;
  logic              in_ready_r;
  logic [DATA_W-1:0] out_instr_r, skid_instr_r;
  logic [OP_W-1:0]   out_op_r, skid_op_r;
  logic              load_out_s, load_skid_s, from_skid_s;

  // Next state and which entry to load this cycle
  always_comb begin
    state_next_s = state_r;
    load_out_s   = 1'b0;
    load_skid_s  = 1'b0;
    from_skid_s  = 1'b0;
    case (state_r)
      EMPTY: begin
        if (push) begin
          state_next_s = FULL;
          load_out_s   = 1'b1;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (fire && push) begin
          state_next_s = FULL;
          load_out_s   = 1'b1;
        end else if (fire) begin
          state_next_s = EMPTY;
        end else if (push) begin
          state_next_s = SKID;
          load_skid_s  = 1'b1;
        end else begin
          state_next_s = FULL;
        end
      end
      SKID: begin
        if (fire) begin
          state_next_s = FULL;
          from_skid_s  = 1'b1;
        end else begin
          state_next_s = SKID;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State, storage and ready registers; ready drops only while SKID is held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= EMPTY;
      in_ready_r   <= 1'b0;
      out_instr_r  <= '0;
      out_op_r     <= '0;
      skid_instr_r <= '0;
      skid_op_r    <= '0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s != SKID);
      if (load_out_s) begin
        out_instr_r <= push_instr;
        out_op_r    <= push_op;
      end else if (from_skid_s) begin
        out_instr_r <= skid_instr_r;
        out_op_r    <= skid_op_r;
      end else begin
        out_instr_r <= out_instr_r;
        out_op_r    <= out_op_r;
      end
      if (load_skid_s) begin
        skid_instr_r <= push_instr;
        skid_op_r    <= push_op;
      end else begin
        skid_instr_r <= skid_instr_r;
        skid_op_r    <= skid_op_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign buf_valid = (state_r != EMPTY);
  assign out_instr = out_instr_r;
  assign out_op    = out_op_r;

endmodule

// File: rtl/decode_dispatch.sv
// Decode-stage opcode dispatcher: routes each legal instruction word to one of
// NUM_UNITS channels; illegal opcodes are consumed, pulsed and counted.
module decode_dispatch #(
  parameter int DATA_W    = 16,
  parameter int OP_W      = 6,
  parameter int NUM_UNITS = 18,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_instr,
  output logic [NUM_UNITS-1:0] out_valid,
  input  logic [NUM_UNITS-1:0] out_ready,
  output logic [DATA_W-1:0]    out_instr,
  output logic                 illegal,
  output logic [CNT_W-1:0]     illegal_count
);
  import decode_pkg::*;

  logic [OP_W-1:0]      in_op_s, out_op_s;
  logic                 accept_s, legal_s, push_s, fire_s, buf_valid_s;
  logic [NUM_UNITS-1:0] out_valid_s;
  logic                 illegal_r;
  logic [CNT_W-1:0]     illegal_count_r;

  assign in_op_s  = in_instr[OP_MSB:OP_LSB];
  assign legal_s  = op_is_legal(in_op_s);
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && legal_s;

  dispatch_skid #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_instr (in_instr),
    .push_op    (in_op_s),
    .fire       (fire_s),
    .in_ready   (in_ready),
    .buf_valid  (buf_valid_s),
    .out_instr  (out_instr),
    .out_op     (out_op_s)
  );

  // One-hot decode of the buffered opcode onto the channel valids
  always_comb begin
    out_valid_s = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      out_valid_s[k] = buf_valid_s && (out_op_s == OP_W'(k));
    end
  end

  // Only the selected channel's ready can complete a transfer
  assign fire_s    = |(out_valid_s & out_ready);
  assign out_valid = out_valid_s;

  // Illegal pulse and saturating illegal-opcode counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_r       <= 1'b0;
      illegal_count_r <= '0;
    end else begin
      illegal_r <= accept_s && !legal_s;
      if (accept_s && !legal_s && (illegal_count_r != {CNT_W{1'b1}})) begin
        illegal_count_r <= illegal_count_r + CNT_W'(1);
      end else begin
        illegal_count_r <= illegal_count_r;
      end
    end
  end

  assign illegal       = illegal_r;
  assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_decode_dispatch.sv
// Self-checking bench for decode_dispatch: directed vector table, backpressure,
// illegal saturation and reset-in-SKID sequences, then a random scoreboard run.
module tb_decode_dispatch;

  localparam logic [17:0] ALL = {18{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0000;
  logic [17:0] out_valid;
  logic [17:0] out_ready = ALL;
  logic [15:0] out_instr;
  logic        illegal;
  logic [7:0]  illegal_count;

  int n_cmp = 0;
  int n_bad = 0;

  decode_dispatch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [15:0] instr;
    logic [17:0] rdy;
    logic        e_rdy;
    logic [17:0] e_valid;
    logic [15:0] e_instr;
    logic        e_ill;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic e_rdy, input logic [17:0] e_valid,
                         input logic [15:0] e_instr, input logic e_ill, input logic [7:0] e_cnt);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'(e_rdy));
    chk({nm, "_out_valid"}, 32'(out_valid), 32'(e_valid));
    chk({nm, "_out_instr"}, 32'(out_instr), 32'(e_instr));
    chk({nm, "_illegal"}, 32'(illegal), 32'(e_ill));
    chk({nm, "_count"}, 32'(illegal_count), 32'(e_cnt));
  endtask

  function automatic vec_t mk(input logic vin, input logic [15:0] instr, input logic [17:0] rdy,
                              input logic e_rdy, input logic [17:0] e_valid, input logic [15:0] e_instr,
                              input logic e_ill, input logic [7:0] e_cnt);
    vec_t v;
    v.vin = vin; v.instr = instr; v.rdy = rdy; v.e_rdy = e_rdy;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_ill = e_ill; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Push A, B to op 3 with unit 3 stalled, leaving the dispatcher in SKID
  task automatic fill_skid(input logic [15:0] a, input logic [15:0] b);
    out_ready = ALL & ~(18'd1 << 3);
    in_valid = 1'b1; in_instr = a;
    tick();
    in_instr = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] q[$];
    logic [5:0]  op;
    logic [7:0]  exp_cnt;
    logic        exp_ill;
    logic        acc, fired;

    // Reset
    tick();
    tick();
    chk_all("reset", 1'b0, 18'd0, 16'h0000, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", 1'b1, 18'd0, 16'h0000, 1'b0, 8'd0);

    // Vector table: streaming all legal opcodes, then illegal between legal words
    for (int i = 0; i < 18; i++) begin
      w = {6'(i), 10'(i * 37)};
      vecs.push_back(mk(1'b1, w, ALL, 1'b1, 18'd1 << i, w, 1'b0, 8'd0));
    end
    vecs.push_back(mk(1'b1, 16'h4123, ALL, 1'b1, 18'd1 << 16, 16'h4123, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 16'h0C05, ALL, 1'b1, 18'd1 << 3, 16'h0C05, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 16'hFC00, ALL, 1'b1, 18'd0, 16'h0C05, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 16'h1407, ALL, 1'b1, 18'd1 << 5, 16'h1407, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 16'h0000, ALL, 1'b1, 18'd0, 16'h1407, 1'b0, 8'd1));
    foreach (vecs[i]) begin
      in_valid = vecs[i].vin; in_instr = vecs[i].instr; out_ready = vecs[i].rdy;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_valid, vecs[i].e_instr,
              vecs[i].e_ill, vecs[i].e_cnt);
    end

    // Backpressure on unit 3: A held, B into skid, C refused until release
    fill_skid(16'h0C11, 16'h0C22);
    chk_all("bp_skid", 1'b0, 18'd1 << 3, 16'h0C11, 1'b0, 8'd1);
    in_valid = 1'b1; in_instr = 16'h0C33;
    tick();
    chk_all("bp_hold", 1'b0, 18'd1 << 3, 16'h0C11, 1'b0, 8'd1);
    in_valid = 1'b0; out_ready = ALL;
    tick();
    chk_all("bp_rel_b", 1'b1, 18'd1 << 3, 16'h0C22, 1'b0, 8'd1);
    in_valid = 1'b1; in_instr = 16'h0C33;
    tick();
    chk_all("bp_c", 1'b1, 18'd1 << 3, 16'h0C33, 1'b0, 8'd1);
    in_valid = 1'b0;
    tick();
    chk_all("bp_drain", 1'b1, 18'd0, 16'h0C33, 1'b0, 8'd1);

    // 260 back-to-back illegal words: pulse every word, count saturates
    for (int k = 1; k <= 260; k++) begin
      in_valid = 1'b1; in_instr = 16'hFC00 | 16'(k);
      tick();
      chk($sformatf("sat_ill%0d", k), 32'(illegal), 32'd1);
      chk($sformatf("sat_cnt%0d", k), 32'(illegal_count), (k + 1 > 255) ? 32'd255 : 32'(k + 1));
      chk($sformatf("sat_val%0d", k), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk_all("sat_end", 1'b1, 18'd0, 16'h0C33, 1'b0, 8'd255);

    // Reset while in SKID: both entries discarded, counter cleared
    fill_skid(16'h0C44, 16'h0C55);
    chk_all("rs_skid", 1'b0, 18'd1 << 3, 16'h0C44, 1'b0, 8'd255);
    rst_n = 1'b0; out_ready = ALL;
    tick();
    chk_all("rs_reset", 1'b0, 18'd0, 16'h0000, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();
    chk_all("rs_release", 1'b1, 18'd0, 16'h0000, 1'b0, 8'd0);
    tick();
    chk_all("rs_idle", 1'b1, 18'd0, 16'h0000, 1'b0, 8'd0);

    // Random mixed traffic against an order/routing scoreboard
    exp_cnt = 8'd0;
    exp_ill = 1'b0;
    for (int c = 0; c < 400; c++) begin
      op = 6'($urandom_range(0, 23));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = {op, 10'($urandom)};
      out_ready = (c >= 380) ? ALL : 18'($urandom);
      if (c >= 380) in_valid = 1'b0;
      #3;
      chk("rnd_onehot", 32'($countones(out_valid) <= 1), 32'd1);
      chk("rnd_illegal", 32'(illegal), 32'(exp_ill));
      chk("rnd_count", 32'(illegal_count), 32'(exp_cnt));
      acc   = in_valid && in_ready;
      fired = |(out_valid & out_ready);
      if (fired) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_fire", 32'(out_instr), 32'hFFFFFFFF);
        end else begin
          chk("rnd_order", 32'(out_instr), 32'(q[0]));
          chk("rnd_route", 32'(out_valid), 32'(18'd1 << q[0][15:10]));
          void'(q.pop_front());
        end
      end
      exp_ill = acc && (in_instr[15:10] >= 6'd18);
      if (exp_ill && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      if (acc && in_instr[15:10] < 6'd18) q.push_back(in_instr);
      tick();
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_final_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
